// File: rtl/graphics_pkg.sv
// graphics_pkg: display geometry, pixel format and scanout FSM encoding shared by the display path.
package graphics_pkg;
    localparam int SCREEN_WIDTH       = 640;
    localparam int SCREEN_HEIGHT      = 480;
    localparam int MAX_READ_BURST_LEN = 128;
    localparam int RGB_W              = 16;
    localparam int ADDR_W             = 22;
    typedef enum logic [1:0] {IDLE, WAIT_SPACE, REQ, FRAME_END} state_t;
endpackage

// File: rtl/pixel_fifo.sv
// pixel_fifo: show-ahead pixel FIFO with synchronous flush and occupancy count.
module pixel_fifo #(
    parameter int AW = 10
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          flush,
    input  logic                          push,
    input  logic [graphics_pkg::RGB_W-1:0] din,
    input  logic                          pop,
    output logic [graphics_pkg::RGB_W-1:0] dout,
    output logic [AW:0]                   count,
    output logic                          empty
);
    import graphics_pkg::*;
    logic [RGB_W-1:0] mem [2**AW];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             do_push, do_pop;
    assign empty   = count == '0;
    assign do_push = push && !count[AW];
    assign do_pop  = pop && !empty;
    assign dout    = empty ? '0 : mem[rd_ptr];
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end
    always_ff @(posedge clk) if (do_push) mem[wr_ptr] <= din;
endmodule

// File: rtl/fb_scanout_reader.sv
// fb_scanout_reader: fetches a frame from the frame buffer in bursts sized to FIFO space and
// presents it pixel by pixel to the display consumer.
module fb_scanout_reader #(
    parameter int SCREEN_WIDTH       = graphics_pkg::SCREEN_WIDTH,
    parameter int SCREEN_HEIGHT      = graphics_pkg::SCREEN_HEIGHT,
    parameter int MAX_READ_BURST_LEN = graphics_pkg::MAX_READ_BURST_LEN,
    parameter int BURST_BITS         = 10,
    parameter int FIFO_AW            = 10
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            enable,
    input  logic                            frame_start,
    output logic                            read_burst_req,
    output logic [graphics_pkg::ADDR_W-1:0] addr,
    output logic [BURST_BITS-1:0]           read_burst_len,
    input  logic                            read_burst_data_valid,
    input  logic [graphics_pkg::RGB_W-1:0]  read_burst_data,
    input  logic                            read_burst_finish,
    input  logic                            pixel_req,
    output logic [graphics_pkg::RGB_W-1:0]  pixel,
    output logic                            pixel_valid,
    output logic                            underflow,
    output logic                            frame_done
);
    import graphics_pkg::*;
    localparam logic [ADDR_W-1:0] FRAME_PIXELS = ADDR_W'(SCREEN_WIDTH * SCREEN_HEIGHT);
    localparam logic [ADDR_W-1:0] MAX_LEN      = ADDR_W'(MAX_READ_BURST_LEN);
    localparam logic [ADDR_W-1:0] FIFO_DEPTH   = ADDR_W'(2**FIFO_AW);
    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   next_addr, remaining, burst_w, free_w, len_w;
    logic [BURST_BITS-1:0] beat_cnt;
    logic [FIFO_AW:0]    fifo_count;
    logic                fifo_empty, restart_pending, restart;
    logic                start_frame, latch_burst, advance, flush, push;
    assign burst_w        = remaining < MAX_LEN ? remaining : MAX_LEN;
    assign free_w         = FIFO_DEPTH - ADDR_W'(fifo_count);
    assign len_w          = ADDR_W'(read_burst_len);
    assign restart        = restart_pending || frame_start;
    assign read_burst_req = state == REQ;
    assign frame_done     = state == FRAME_END;
    assign pixel_valid    = !fifo_empty;
    // beats beyond the requested length, or outside a burst, are never stored
    assign push = state == REQ && read_burst_data_valid && beat_cnt < read_burst_len;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_nxt;
    end
    always_comb begin
        state_nxt   = state;
        start_frame = 1'b0;
        latch_burst = 1'b0;
        advance     = 1'b0;
        flush       = 1'b0;
        case (state)
            IDLE: if (enable && frame_start) begin
                start_frame = 1'b1;
                state_nxt   = WAIT_SPACE;
            end
            WAIT_SPACE: begin
                flush       = frame_start;
                start_frame = frame_start;
                if (!enable) state_nxt = IDLE;
                else if (!frame_start && free_w >= burst_w) begin
                    latch_burst = 1'b1;
                    state_nxt   = REQ;
                end
            end
            REQ: if (read_burst_finish) begin
                flush       = restart;
                start_frame = restart;
                advance     = !restart;
                state_nxt   = !restart && remaining == len_w ? FRAME_END : enable ? WAIT_SPACE : IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            next_addr       <= '0;
            remaining       <= '0;
            addr            <= '0;
            read_burst_len  <= '0;
            beat_cnt        <= '0;
            restart_pending <= 1'b0;
            underflow       <= 1'b0;
        end else begin
            if (start_frame) begin
                next_addr <= '0;
                remaining <= FRAME_PIXELS;
            end else if (advance) begin
                next_addr <= next_addr + len_w;
                remaining <= remaining - len_w;
            end
            if (latch_burst) begin
                addr           <= next_addr;
                read_burst_len <= BURST_BITS'(burst_w);
                beat_cnt       <= '0;
            end else if (push) begin
                beat_cnt <= beat_cnt + 1'b1;
            end
            restart_pending <= state == REQ && !read_burst_finish && restart;
            underflow       <= !frame_start && (underflow || (pixel_req && fifo_empty));
        end
    end
    pixel_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (flush),
        .push  (push),
        .din   (read_burst_data),
        .pop   (pixel_req),
        .dout  (pixel),
        .count (fifo_count),
        .empty (fifo_empty)
    );
endmodule

// File: doc/fb_scanout_reader.md
FB_SCANOUT_READER -- requirements
Module: fb_scanout_reader

Interface
REQ-001 SHALL have parameter SCREEN_WIDTH, default 640, pixels per line.
REQ-002 SHALL have parameter SCREEN_HEIGHT, default 480, lines per frame.
REQ-003 SHALL have parameter MAX_READ_BURST_LEN, default 128, maximum beats per read burst.
REQ-004 SHALL have parameter BURST_BITS, default 10, width of read_burst_len.
REQ-005 SHALL have parameter FIFO_AW, default 10, pixel FIFO address width; depth is 2^FIFO_AW and is at least MAX_READ_BURST_LEN.
REQ-006 SHALL have port clk, input, 1, clock; all logic rises on posedge clk.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous, active-low.
REQ-008 SHALL have port enable, input, 1, permits new frames and new bursts.
REQ-009 SHALL have port frame_start, input, 1, one-cycle pulse that starts or restarts a frame at pixel 0.
REQ-010 SHALL have port read_burst_req, output, 1, burst request to the frame-buffer controller.
REQ-011 SHALL have port addr, output, 22, pixel index of the first beat of the burst.
REQ-012 SHALL have port read_burst_len, output, BURST_BITS, beats in the burst.
REQ-013 SHALL have port read_burst_data_valid, input, 1, one returned beat is present.
REQ-014 SHALL have port read_burst_data, input, 16, RGB565 beat.
REQ-015 SHALL have port read_burst_finish, input, 1, one-cycle pulse after the last beat.
REQ-016 SHALL have port pixel_req, input, 1, consumer pop.
REQ-017 SHALL have port pixel, output, 16, FIFO head, show-ahead.
REQ-018 SHALL have port pixel_valid, output, 1, FIFO not empty.
REQ-019 SHALL have port underflow, output, 1, sticky: pixel_req was asserted while the FIFO was empty.
REQ-020 SHALL have port frame_done, output, 1, one-cycle pulse when the last burst of a frame finishes.

Function
REQ-021 SHALL use FSM states IDLE, WAIT_SPACE, REQ, FRAME_END.
REQ-022 IDLE: on enable && frame_start, SHALL set next_addr=0 and remaining=SCREEN_WIDTH*SCREEN_HEIGHT, then go to WAIT_SPACE.
REQ-023 WAIT_SPACE: when enable is low, SHALL go to IDLE; otherwise, when free FIFO entries >= min(remaining, MAX_READ_BURST_LEN), SHALL latch addr and read_burst_len and go to REQ.
REQ-024 REQ: read_burst_req SHALL be high, with addr and read_burst_len held stable, until the cycle in which read_burst_finish is sampled high.
REQ-025 On finish, SHALL set next_addr += len and remaining -= len; if remaining==0 go to FRAME_END, else go to WAIT_SPACE.
REQ-026 FRAME_END: frame_done SHALL be high for exactly one cycle, then go to IDLE.
REQ-027 Each read_burst_data_valid beat SHALL be pushed into the FIFO, up to read_burst_len beats per burst; excess beats SHALL be dropped.
REQ-028 Beats arriving outside REQ SHALL be dropped.
REQ-029 A pop SHALL occur when pixel_req && pixel_valid, and the next entry SHALL appear on pixel in the following cycle.
REQ-030 pixel SHALL read 16'h0000 when the FIFO is empty.
REQ-031 A simultaneous push and pop SHALL leave the occupancy unchanged.
REQ-032 pixel_req while empty SHALL set underflow, which SHALL stay set until reset or frame_start.
REQ-033 frame_start in WAIT_SPACE SHALL flush the FIFO and restart the frame at pixel 0 on the next cycle.
REQ-034 frame_start in REQ SHALL latch restart_pending; at finish the block SHALL flush the FIFO and restart at pixel 0 instead of advancing.
REQ-035 A flush SHALL win over a push or pop in the same cycle.
REQ-036 enable deassertion in REQ SHALL let the current burst complete, then go to IDLE.
REQ-037 Arithmetic SHALL use 22-bit addresses and 22-bit remaining, with no wrap within a frame.

Reset
REQ-038 While rst_n is low: state=IDLE; read_burst_req=0; addr=0; read_burst_len=0; pixel_valid=0; pixel=0; underflow=0; frame_done=0; FIFO empty; restart_pending=0.
REQ-039 Reset asserted mid-burst SHALL abandon the burst; re-synchronising the controller is the system's responsibility.

Structure
REQ-040 Shared package graphics_pkg SHALL hold SCREEN_WIDTH, SCREEN_HEIGHT, MAX_READ_BURST_LEN, the RGB565 width and the FSM state encoding.
REQ-041 The FIFO SHALL be one sub-module, pixel_fifo (show-ahead, synchronous flush, count output).

Verification (SCREEN_WIDTH=8, SCREEN_HEIGHT=2, MAX_READ_BURST_LEN=4, FIFO_AW=3)
REQ-042 frame_start, controller returning 4 beats per burst -> bursts at addr 0,4,8,12, each with len 4; frame_done pulses once after the 4th finish.
REQ-043 Consumer stalled -> at most 8 pixels buffered; no third request until 4 pixels have been popped.
REQ-044 pixel_req on an empty FIFO at cycle 3 after reset -> underflow=1 and pixel=0; underflow cleared by the next frame_start.
REQ-045 frame_start pulsed during the burst at addr 4 -> that burst completes, the FIFO flushes, and the next request is addr 0.
REQ-046 Controller returns 6 beats for len 4 -> only 4 beats are pushed.
REQ-047 rst_n asserted mid-burst -> all outputs take their reset values immediately; the next frame_start requests addr 0.
